// File: rtl/cart_pkg.sv
// Shared types, header offsets and helpers for the MBC1 cartridge header loader.
package cart_pkg;

    // Scan sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GAP   = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5,
        ST_FAIL  = 3'd6
    } state_t;

    // Error codes reported on the error output.
    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_CKSUM   = 2'd2,
        ERR_SIZE    = 2'd3
    } err_t;

    // Header byte addresses inside the cartridge ROM.
    localparam logic [15:0] HDR_FIRST = 16'h0134;
    localparam logic [15:0] HDR_TYPE  = 16'h0147;
    localparam logic [15:0] HDR_ROM   = 16'h0148;
    localparam logic [15:0] HDR_RAM   = 16'h0149;
    localparam logic [15:0] HDR_CKSUM = 16'h014D;

    // Largest size codes the MBC1 mapper understands.
    localparam logic [7:0] ROM_CODE_MAX = 8'd6;
    localparam logic [7:0] RAM_CODE_MAX = 8'd3;

    // Width of the per-request timeout counter.
    localparam int TMO_W = 8;

    // Header RAM-size code to mapper ram_size encoding: codes 0 and 1 both mean
    // "no usable banked RAM"; unsupported codes map to 0 and are flagged separately.
    function automatic logic [1:0] map_ram_size(input logic [7:0] code);
        logic [1:0] size;
        case (code)
            8'd2:    size = 2'd2;
            8'd3:    size = 2'd3;
            default: size = 2'd0;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/cart_hdr_cksum.sv
// Running header checksum: each enabled byte updates sum <= sum - data - 1 (mod 256).
module cart_hdr_cksum (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic [7:0] i_data,
    output logic [7:0] o_sum
);

    logic [7:0] r_sum;

    // Accumulator: clear at scan launch, fold in one byte per enabled cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            r_sum <= 8'd0;
        end else if (i_clr) begin
            r_sum <= 8'd0;
        end else if (i_en) begin
            r_sum <= r_sum - i_data - 8'd1;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/cart_header_loader.sv
// Boot-time MBC1 configurator: reads header bytes 0x134..0x14D over a req/ack port,
// validates the checksum, and releases mbc_reset once rom/ram/type config is valid.
module cart_header_loader
    import cart_pkg::*;
#(
    parameter int ADR_W        = 21,
    parameter int TIMEOUT      = 255,
    parameter bit AUTO_START   = 1'b1,
    parameter bit STRICT_CKSUM = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             mem_req,
    output logic [ADR_W-1:0] mem_adr,
    input  logic             mem_ack,
    input  logic [7:0]       mem_data,
    output logic             busy,
    output logic             cfg_valid,
    output logic             hdr_ok,
    output logic [1:0]       error,
    output logic [7:0]       mbc_type,
    output logic [2:0]       rom_size,
    output logic [1:0]       ram_size,
    output logic             mbc_reset
);

    // Header addresses widened to the memory port width.
    localparam logic [ADR_W-1:0] A_FIRST = ADR_W'(HDR_FIRST);
    localparam logic [ADR_W-1:0] A_TYPE  = ADR_W'(HDR_TYPE);
    localparam logic [ADR_W-1:0] A_ROM   = ADR_W'(HDR_ROM);
    localparam logic [ADR_W-1:0] A_RAM   = ADR_W'(HDR_RAM);
    localparam logic [ADR_W-1:0] A_CKSUM = ADR_W'(HDR_CKSUM);

    // Unanswered wait cycles allowed before a request is abandoned.
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

    state_t             r_state;
    logic               r_auto;
    logic [ADR_W-1:0]   r_adr;
    logic               r_req;
    logic               r_busy;
    logic               r_cfg_valid;
    logic               r_hdr_ok;
    err_t               r_error;
    logic               r_size_bad;
    logic [7:0]         r_mbc_type;
    logic [2:0]         r_rom_size;
    logic [1:0]         r_ram_size;
    logic               r_mbc_reset;
    logic [TMO_W-1:0]   r_tmo_cnt;

    logic               w_can_launch;
    logic               w_launch;
    logic               w_capture;
    logic               w_ck_en;
    logic [7:0]         w_sum;
    logic [TMO_W-1:0]   w_tmo_next;

    // A scan may only be launched from a resting state; start while busy is ignored.
    assign w_can_launch = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_FAIL);
    assign w_launch     = w_can_launch && (start || r_auto);

    // Acks are honoured only while waiting on an outstanding request.
    assign w_capture    = (r_state == ST_WAIT) && mem_ack;

    // Every header byte except the stored checksum itself feeds the running sum.
    assign w_ck_en      = w_capture && (r_adr != A_CKSUM);

    assign w_tmo_next   = r_tmo_cnt + TMO_W'(1);

    cart_hdr_cksum u_cksum (
        .i_clk  (clk),
        .i_rst  (reset),
        .i_clr  (w_launch),
        .i_en   (w_ck_en),
        .i_data (mem_data),
        .o_sum  (w_sum)
    );

    // Scan sequencer: walks the header, captures fields and owns every registered output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_auto      <= AUTO_START;
            r_adr       <= '0;
            r_req       <= 1'b0;
            r_busy      <= 1'b0;
            r_cfg_valid <= 1'b0;
            r_hdr_ok    <= 1'b0;
            r_error     <= ERR_NONE;
            r_size_bad  <= 1'b0;
            r_mbc_type  <= 8'd0;
            r_rom_size  <= 3'd0;
            r_ram_size  <= 2'd0;
            r_mbc_reset <= 1'b1;
            r_tmo_cnt   <= '0;
        end else begin
            // The auto-start request lives for exactly the first cycle out of reset.
            r_auto <= 1'b0;

            case (r_state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (w_launch) begin
                        r_adr       <= A_FIRST;
                        r_req       <= 1'b1;
                        r_busy      <= 1'b1;
                        r_cfg_valid <= 1'b0;
                        r_mbc_reset <= 1'b1;
                        r_error     <= ERR_NONE;
                        r_size_bad  <= 1'b0;
                        r_tmo_cnt   <= '0;
                        r_state     <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    // Request is already on the bus; start watching for the ack.
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (mem_ack) begin
                        r_req   <= 1'b0;
                        r_state <= ST_GAP;
                        if (r_adr == A_TYPE) begin
                            r_mbc_type <= mem_data;
                        end
                        if (r_adr == A_ROM) begin
                            r_rom_size <= mem_data[2:0];
                            if (mem_data > ROM_CODE_MAX) begin
                                r_size_bad <= 1'b1;
                            end
                        end
                        if (r_adr == A_RAM) begin
                            r_ram_size <= map_ram_size(mem_data);
                            if (mem_data > RAM_CODE_MAX) begin
                                r_size_bad <= 1'b1;
                            end
                        end
                        if (r_adr == A_CKSUM) begin
                            r_hdr_ok <= (mem_data == w_sum);
                        end
                    end else if (w_tmo_next == TMO_LIMIT) begin
                        // Memory never answered: drop the request and give up.
                        r_req   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_error <= ERR_TIMEOUT;
                        r_state <= ST_FAIL;
                    end else begin
                        r_tmo_cnt <= w_tmo_next;
                    end
                end

                ST_GAP: begin
                    // One idle cycle between requests, then either next byte or verdict.
                    if (r_adr == A_CKSUM) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_adr     <= r_adr + ADR_W'(1);
                        r_req     <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= ST_REQ;
                    end
                end

                ST_CHECK: begin
                    // Unsupported size codes outrank a checksum mismatch.
                    if (r_size_bad) begin
                        r_error <= ERR_SIZE;
                        r_busy  <= 1'b0;
                        r_state <= ST_FAIL;
                    end else if (!r_hdr_ok && STRICT_CKSUM) begin
                        r_error <= ERR_CKSUM;
                        r_busy  <= 1'b0;
                        r_state <= ST_FAIL;
                    end else begin
                        r_cfg_valid <= 1'b1;
                        r_mbc_reset <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_DONE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req   = r_req;
    assign mem_adr   = r_adr;
    assign busy      = r_busy;
    assign cfg_valid = r_cfg_valid;
    assign hdr_ok    = r_hdr_ok;
    assign error     = r_error;
    assign mbc_type  = r_mbc_type;
    assign rom_size  = r_rom_size;
    assign ram_size  = r_ram_size;
    assign mbc_reset = r_mbc_reset;

endmodule

// File: tb/tb_cart_header_loader.sv
// Directed bench for cart_header_loader: a strict-checksum and a lenient-checksum
// instance share one header memory model with configurable ack latency.
module tb_cart_header_loader;

    localparam logic [20:0] HOLD_ADR = 21'h140;
    localparam logic [20:0] RST_ADR  = 21'h13A;

    logic        clk;
    logic        reset;
    logic        start;
    logic        mem_ack;
    logic [7:0]  mem_data;

    logic        mem_req;
    logic [20:0] mem_adr;
    logic        busy;
    logic        cfg_valid;
    logic        hdr_ok;
    logic [1:0]  error;
    logic [7:0]  mbc_type;
    logic [2:0]  rom_size;
    logic [1:0]  ram_size;
    logic        mbc_reset;

    logic        ns_mem_req;
    logic [20:0] ns_mem_adr;
    logic        ns_busy;
    logic        ns_cfg_valid;
    logic        ns_hdr_ok;
    logic [1:0]  ns_error;
    logic [7:0]  ns_mbc_type;
    logic [2:0]  ns_rom_size;
    logic [1:0]  ns_ram_size;
    logic        ns_mbc_reset;

    logic [7:0]  hdr [0:25];
    int          lat_min;
    int          lat_max;
    bit          withhold;

    int          n_checks;
    int          n_errors;

    cart_header_loader #(
        .ADR_W        (21),
        .TIMEOUT      (255),
        .AUTO_START   (1'b1),
        .STRICT_CKSUM (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_req   (mem_req),
        .mem_adr   (mem_adr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .busy      (busy),
        .cfg_valid (cfg_valid),
        .hdr_ok    (hdr_ok),
        .error     (error),
        .mbc_type  (mbc_type),
        .rom_size  (rom_size),
        .ram_size  (ram_size),
        .mbc_reset (mbc_reset)
    );

    cart_header_loader #(
        .ADR_W        (21),
        .TIMEOUT      (255),
        .AUTO_START   (1'b1),
        .STRICT_CKSUM (1'b0)
    ) dut_ns (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_req   (ns_mem_req),
        .mem_adr   (ns_mem_adr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .busy      (ns_busy),
        .cfg_valid (ns_cfg_valid),
        .hdr_ok    (ns_hdr_ok),
        .error     (ns_error),
        .mbc_type  (ns_mbc_type),
        .rom_size  (ns_rom_size),
        .ram_size  (ns_ram_size),
        .mbc_reset (ns_mbc_reset)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: acks a request cur_lat cycles after it first appears, one-cycle pulse.
    initial begin : mem_model
        int wait_cnt;
        int cur_lat;
        int idx;
        bit ack_done;
        wait_cnt = 0;
        cur_lat  = 1;
        ack_done = 1'b0;
        mem_ack  = 1'b0;
        mem_data = 8'h00;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (reset || !mem_req) begin
                wait_cnt = 0;
                ack_done = 1'b0;
            end else if (!ack_done) begin
                if (wait_cnt == 0) cur_lat = int'($urandom_range(lat_max, lat_min));
                if (wait_cnt >= cur_lat && !(withhold && mem_adr == HOLD_ADR)) begin
                    idx = int'(mem_adr) - 32'h134;
                    mem_data = (idx >= 0 && idx < 26) ? hdr[idx] : 8'hFF;
                    mem_ack  = 1'b1;
                    ack_done = 1'b1;
                end else begin
                    wait_cnt = wait_cnt + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) else begin
            n_errors = n_errors + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Zero the header, then place type/rom/ram codes and the stored checksum.
    task automatic set_hdr(input logic [7:0] t, input logic [7:0] r, input logic [7:0] m,
                           input logic [7:0] ck);
        for (int i = 0; i < 26; i++) hdr[i] = 8'h00;
        hdr[19] = t;
        hdr[20] = r;
        hdr[21] = m;
        hdr[25] = ck;
    endtask

    // Count rising edges until busy drops (edge 1 is the one sampling start);
    // optionally pulse start mid-scan. n_edges = -1 if the budget expires.
    task automatic run_until_idle(input int budget, input int poke_at, output int n_edges,
                                  output logic cv1, output logic mr1);
        n_edges = -1;
        cv1 = 1'bx;
        mr1 = 1'bx;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            start = (i == poke_at);
            if (i == 1) begin
                cv1 = cfg_valid;
                mr1 = mbc_reset;
            end
            if (!busy && i > 1) begin
                n_edges = i;
                return;
            end
        end
        start = 1'b0;
    endtask

    task automatic launch(input int budget, input int poke_at, output int n_edges,
                          output logic cv1, output logic mr1);
        @(negedge clk);
        start = 1'b1;
        run_until_idle(budget, poke_at, n_edges, cv1, mr1);
    endtask

    initial begin
        int   n;
        logic cv1;
        logic mr1;
        bit   found;

        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        start    = 1'b0;
        withhold = 1'b0;
        lat_min  = 1;
        lat_max  = 1;
        set_hdr(8'h00, 8'h00, 8'h00, 8'hE7);

        // Reset values while reset is held.
        repeat (3) @(posedge clk);
        #1;
        check("rst mem_req",   32'(mem_req),   32'd0);
        check("rst mem_adr",   32'(mem_adr),   32'd0);
        check("rst busy",      32'(busy),      32'd0);
        check("rst cfg_valid", 32'(cfg_valid), 32'd0);
        check("rst hdr_ok",    32'(hdr_ok),    32'd0);
        check("rst error",     32'(error),     32'd0);
        check("rst mbc_type",  32'(mbc_type),  32'd0);
        check("rst rom_size",  32'(rom_size),  32'd0);
        check("rst ram_size",  32'(ram_size),  32'd0);
        check("rst mbc_reset", 32'(mbc_reset), 32'd1);

        // Auto-start: scan begins on the first edge after reset release.
        @(negedge clk);
        reset = 1'b0;
        run_until_idle(300, 0, n, cv1, mr1);
        check("auto latency",   32'(n),         32'd80);
        check("auto cfg_valid", 32'(cfg_valid), 32'd1);
        check("auto hdr_ok",    32'(hdr_ok),    32'd1);

        // Case 1 by start; a start pulse coinciding with an ack must be ignored.
        launch(300, 41, n, cv1, mr1);
        check("t1 latency",      32'(n),            32'd80);
        check("t1 cfg drop",     32'(cv1),          32'd0);
        check("t1 mbcrst rise",  32'(mr1),          32'd1);
        check("t1 cfg_valid",    32'(cfg_valid),    32'd1);
        check("t1 mbc_reset",    32'(mbc_reset),    32'd0);
        check("t1 hdr_ok",       32'(hdr_ok),       32'd1);
        check("t1 error",        32'(error),        32'd0);
        check("t1 ns cfg_valid", 32'(ns_cfg_valid), 32'd1);

        // Case 2: populated type/size fields.
        set_hdr(8'h01, 8'h05, 8'h03, 8'hDE);
        launch(300, 0, n, cv1, mr1);
        check("t2 latency",  32'(n),         32'd80);
        check("t2 mbc_type", 32'(mbc_type),  32'h01);
        check("t2 rom_size", 32'(rom_size),  32'd5);
        check("t2 ram_size", 32'(ram_size),  32'd3);
        check("t2 hdr_ok",   32'(hdr_ok),    32'd1);
        check("t2 cfg",      32'(cfg_valid), 32'd1);

        // RAM code 1 maps to 0.
        set_hdr(8'h01, 8'h05, 8'h01, 8'hE0);
        launch(300, 0, n, cv1, mr1);
        check("t2b ram_size", 32'(ram_size), 32'd0);
        check("t2b hdr_ok",   32'(hdr_ok),   32'd1);

        // Case 3: wrong checksum byte.
        set_hdr(8'h00, 8'h00, 8'h00, 8'h00);
        launch(300, 0, n, cv1, mr1);
        check("t3 error",        32'(error),        32'd2);
        check("t3 cfg_valid",    32'(cfg_valid),    32'd0);
        check("t3 mbc_reset",    32'(mbc_reset),    32'd1);
        check("t3 hdr_ok",       32'(hdr_ok),       32'd0);
        check("t3 ns cfg_valid", 32'(ns_cfg_valid), 32'd1);
        check("t3 ns hdr_ok",    32'(ns_hdr_ok),    32'd0);
        check("t3 ns error",     32'(ns_error),     32'd0);
        check("t3 ns mbc_reset", 32'(ns_mbc_reset), 32'd0);

        // Case 4: ROM code 7 with a correct checksum.
        set_hdr(8'h00, 8'h07, 8'h00, 8'hE0);
        launch(300, 0, n, cv1, mr1);
        check("t4 error",     32'(error),     32'd3);
        check("t4 hdr_ok",    32'(hdr_ok),    32'd1);
        check("t4 cfg_valid", 32'(cfg_valid), 32'd0);
        check("t4 mbc_reset", 32'(mbc_reset), 32'd1);
        check("t4 rom_size",  32'(rom_size),  32'd7);
        check("t4 ns error",  32'(ns_error),  32'd3);

        // RAM code 4 with a correct checksum.
        set_hdr(8'h00, 8'h00, 8'h04, 8'hE3);
        launch(300, 0, n, cv1, mr1);
        check("t4b error",    32'(error),    32'd3);
        check("t4b ram_size", 32'(ram_size), 32'd0);

        // Case 5: ack withheld at 0x140, then retried with ack restored.
        set_hdr(8'h01, 8'h05, 8'h03, 8'hDE);
        withhold = 1'b1;
        launch(600, 0, n, cv1, mr1);
        check("t5 timeout window", 32'(n >= 290 && n <= 296), 32'd1);
        check("t5 error",     32'(error),     32'd1);
        check("t5 mem_req",   32'(mem_req),   32'd0);
        check("t5 cfg_valid", 32'(cfg_valid), 32'd0);
        check("t5 mbc_reset", 32'(mbc_reset), 32'd1);
        withhold = 1'b0;
        launch(300, 0, n, cv1, mr1);
        check("t5 retry latency", 32'(n),         32'd80);
        check("t5 retry error",   32'(error),     32'd0);
        check("t5 retry cfg",     32'(cfg_valid), 32'd1);

        // Case 6: asynchronous reset while fetching 0x13A.
        @(negedge clk);
        start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (mem_req && mem_adr == RST_ADR) begin
                found = 1'b1;
                break;
            end
        end
        check("t6 reached 0x13A", 32'(found), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t6 mem_req",   32'(mem_req),   32'd0);
        check("t6 mem_adr",   32'(mem_adr),   32'd0);
        check("t6 busy",      32'(busy),      32'd0);
        check("t6 cfg_valid", 32'(cfg_valid), 32'd0);
        check("t6 mbc_type",  32'(mbc_type),  32'd0);
        check("t6 ram_size",  32'(ram_size),  32'd0);
        check("t6 mbc_reset", 32'(mbc_reset), 32'd1);
        check("t6 ns busy",   32'(ns_busy),   32'd0);

        // Auto rescan after release, with random ack latency.
        lat_min = 1;
        lat_max = 20;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_until_idle(2000, 0, n, cv1, mr1);
        check("t6 rescan done", 32'(n > 0),       32'd1);
        check("t6 cfg_valid2",  32'(cfg_valid),   32'd1);
        check("t6 mbc_type2",   32'(mbc_type),    32'h01);
        check("t6 rom_size2",   32'(rom_size),    32'd5);
        check("t6 ram_size2",   32'(ram_size),    32'd3);
        check("t6 hdr_ok2",     32'(hdr_ok),      32'd1);
        check("t6 error2",      32'(error),       32'd0);

        // Random latency with a bad checksum.
        set_hdr(8'h00, 8'h00, 8'h00, 8'h00);
        launch(2000, 0, n, cv1, mr1);
        check("rl error",        32'(error),        32'd2);
        check("rl ns cfg_valid", 32'(ns_cfg_valid), 32'd1);
        check("rl ns hdr_ok",    32'(ns_hdr_ok),    32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
